// File: rtl/core_pipe_pkg.sv
// Shared types for the core pipeline stages: skid-stage state encoding and the
// decode->regfile payload bundle.
package core_pipe_pkg;

    // Encoding is {skid_valid, main_valid}; 2'b10 cannot occur.
    typedef enum logic [1:0] {
        EMPTY = 2'b00,
        ONE   = 2'b01,
        TWO   = 2'b11
    } pipe_state_e;

    typedef struct packed {
        logic [4:0]  rs1;
        logic [4:0]  rs2;
        logic [4:0]  rd;
        logic [63:0] pc;
        logic [63:0] imm;      // already sign-extended by decode
        logic [5:0]  shamt;
        logic [6:0]  opcode;
        logic [7:0]  instr_id;
        logic        branch;
        logic        regw;
        logic        memr;
        logic        memw;
    } decode_rf_bundle_t;

    localparam int DECODE_RF_W = $bits(decode_rf_bundle_t);

    function automatic logic [1:0] held_entries(input pipe_state_e s);
        logic [1:0] n;
        n = 2'd0;
        case (s)
            ONE:     n = 2'd1;
            TWO:     n = 2'd2;
            default: n = 2'd0;
        endcase
        return n;
    endfunction

endpackage

// File: rtl/pipe_sat_counter.sv
// Saturating up-counter with asynchronous active-low clear; sticks at all-ones.
module pipe_sat_counter #(
    parameter int CNT_W = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             inc,
    output logic [CNT_W-1:0] count
);

    logic [CNT_W-1:0] count_q;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            count_q <= '0;
        end else if (inc && (count_q != '1)) begin
            count_q <= count_q + 1'b1;
        end
    end

    assign count = count_q;

endmodule

// File: rtl/pipe_stage_skid.sv
// Generic valid/ready pipeline stage with a two-entry skid buffer and sync flush.
// Optional perf counters are built when PIPE_STAGE_PERF_EN is defined.
module pipe_stage_skid
    import core_pipe_pkg::*;
#(
    parameter int               WIDTH   = 64,
    parameter logic [WIDTH-1:0] RST_VAL = '0,
    parameter int               CNT_W   = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             flush,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_data,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_data,
    output logic [1:0]       occupancy,
    output logic [CNT_W-1:0] stall_cnt,
    output logic [CNT_W-1:0] bubble_cnt
);

    // Handshake: a beat moves on a rising edge where valid and ready are both
    // high; once valid is raised, the payload holds until that beat completes.

    pipe_state_e      state_q;
    pipe_state_e      state_d;
    logic [WIDTH-1:0] main_data;
    logic [WIDTH-1:0] skid_data;
    logic             in_fire;
    logic             out_fire;
    logic             load_main;
    logic             main_from_skid;
    logic             load_skid;

    assign in_fire  = in_valid & in_ready;
    assign out_fire = out_valid & out_ready;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= EMPTY;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d        = state_q;
        load_main      = 1'b0;
        main_from_skid = 1'b0;
        load_skid      = 1'b0;
        if (flush) begin
            state_d = EMPTY;
        end else begin
            case (state_q)
                EMPTY: begin
                    if (in_fire) begin
                        state_d   = ONE;
                        load_main = 1'b1;
                    end
                end
                ONE: begin
                    if (in_fire && out_fire) begin
                        load_main = 1'b1;
                    end else if (in_fire) begin
                        state_d   = TWO;
                        load_skid = 1'b1;
                    end else if (out_fire) begin
                        state_d = EMPTY;
                    end
                end
                TWO: begin
                    // in_ready is low here, so only the drain can happen.
                    if (out_fire) begin
                        state_d        = ONE;
                        load_main      = 1'b1;
                        main_from_skid = 1'b1;
                    end
                end
                default: state_d = EMPTY;
            endcase
        end
    end

    always_comb begin
        out_valid = (state_q != EMPTY);
        in_ready  = (state_q != TWO);
        occupancy = held_entries(state_q);
        out_data  = main_data;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            main_data <= RST_VAL;
            skid_data <= RST_VAL;
        end else if (flush) begin
            main_data <= RST_VAL;
            skid_data <= RST_VAL;
        end else begin
            if (load_main) begin
                main_data <= main_from_skid ? skid_data : in_data;
            end
            if (load_skid) begin
                skid_data <= in_data;
            end
        end
    end

`ifdef PIPE_STAGE_PERF_EN
    pipe_sat_counter #(.CNT_W(CNT_W)) u_stall_cnt (
        .clk   (clk),
        .rst   (rst),
        .inc   (out_valid & ~out_ready),
        .count (stall_cnt)
    );

    pipe_sat_counter #(.CNT_W(CNT_W)) u_bubble_cnt (
        .clk   (clk),
        .rst   (rst),
        .inc   (~out_valid),
        .count (bubble_cnt)
    );
`else
    assign stall_cnt  = '0;
    assign bubble_cnt = '0;
`endif

endmodule

// File: tb/tb_pipe_stage_skid.sv
// Bench for pipe_stage_skid: directed scenarios plus random traffic, all checked
// every cycle against a queue model of the held entries.
module tb_pipe_stage_skid;

    localparam int               W     = 16;
    localparam logic [W-1:0]     RVAL  = 16'h5A5A;
    localparam int               CW    = 2;

    logic          clk = 1'b0;
    logic          rst = 1'b0;
    logic          flush = 1'b0;
    logic          in_valid = 1'b0;
    logic          in_ready;
    logic [W-1:0]  in_data = '0;
    logic          out_valid;
    logic          out_ready = 1'b0;
    logic [W-1:0]  out_data;
    logic [1:0]    occupancy;
    logic [CW-1:0] stall_cnt;
    logic [CW-1:0] bubble_cnt;

    int total = 0;
    int bad   = 0;

    // Model: entries held by the stage, oldest first.
    logic [W-1:0]  exp_q[$];
    logic [W-1:0]  last_data = RVAL;
    logic [CW-1:0] stall_m = '0;
    logic [CW-1:0] bubble_m = '0;

    pipe_stage_skid #(.WIDTH(W), .RST_VAL(RVAL), .CNT_W(CW)) dut (
        .clk        (clk),
        .rst        (rst),
        .flush      (flush),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_data    (in_data),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_data   (out_data),
        .occupancy  (occupancy),
        .stall_cnt  (stall_cnt),
        .bubble_cnt (bubble_cnt)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(negedge clk);
        #1;
    endtask

    task automatic drive(input logic v, input logic [W-1:0] d, input logic ordy, input logic fl);
        in_valid  = v;
        in_data   = d;
        out_ready = ordy;
        flush     = fl;
    endtask

    always @(posedge clk or negedge rst) begin
        bit ifire;
        bit ofire;
        if (!rst) begin
            exp_q.delete();
            last_data = RVAL;
            stall_m   = '0;
            bubble_m  = '0;
        end else begin
`ifdef PIPE_STAGE_PERF_EN
            if (exp_q.size() > 0 && !out_ready && stall_m != '1) stall_m = stall_m + 1'b1;
            if (exp_q.size() == 0 && bubble_m != '1) bubble_m = bubble_m + 1'b1;
`endif
            ifire = in_valid && (exp_q.size() < 2);
            ofire = (exp_q.size() > 0) && out_ready;
            if (flush) begin
                exp_q.delete();
                last_data = RVAL;
            end else begin
                if (ofire) void'(exp_q.pop_front());
                if (ifire) exp_q.push_back(in_data);
                if (exp_q.size() > 0) last_data = exp_q[0];
            end
        end
    end

    always @(negedge clk) begin
        check("cyc_out_valid", W'(out_valid), W'(exp_q.size() > 0));
        check("cyc_out_data", out_data, last_data);
        check("cyc_in_ready", W'(in_ready), W'(exp_q.size() < 2));
        check("cyc_occupancy", W'(occupancy), W'(exp_q.size()));
        check("cyc_stall_cnt", W'(stall_cnt), W'(stall_m));
        check("cyc_bubble_cnt", W'(bubble_cnt), W'(bubble_m));
    end

    initial begin
        repeat (3) tick();
        check("rst_out_valid", W'(out_valid), '0);
        check("rst_in_ready", W'(in_ready), W'(1));
        check("rst_out_data", out_data, RVAL);
        check("rst_occupancy", W'(occupancy), '0);
        rst = 1'b1;

`ifdef PIPE_STAGE_PERF_EN
        repeat (4) tick();
        check("perf_bubble_sat", W'(bubble_cnt), W'(3));
        drive(1'b1, 16'h0099, 1'b0, 1'b0);
        tick();
        drive(1'b0, '0, 1'b0, 1'b0);
        repeat (5) tick();
        check("perf_stall_sat", W'(stall_cnt), W'(3));
        drive(1'b0, '0, 1'b1, 1'b0);
        tick();
`endif

        // single beat, one-cycle latency
        drive(1'b1, 16'h00A5, 1'b1, 1'b0);
        tick();
        check("a5_out_valid", W'(out_valid), W'(1));
        check("a5_out_data", out_data, 16'h00A5);
        check("a5_occupancy", W'(occupancy), W'(1));
        check("a5_in_ready", W'(in_ready), W'(1));
        drive(1'b0, '0, 1'b1, 1'b0);
        tick();

        // back-to-back stream, no bubbles
        for (int i = 1; i <= 8; i++) begin
            drive(1'b1, W'(i), 1'b1, 1'b0);
            tick();
            check("stream_data", out_data, W'(i));
            check("stream_valid", W'(out_valid), W'(1));
            check("stream_in_ready", W'(in_ready), W'(1));
        end
        drive(1'b0, '0, 1'b1, 1'b0);
        tick();

        // backpressure fills the skid, then drains in order
        drive(1'b1, 16'h0011, 1'b0, 1'b0);
        tick();
        drive(1'b1, 16'h0022, 1'b0, 1'b0);
        tick();
        check("bp_occupancy", W'(occupancy), W'(2));
        check("bp_in_ready", W'(in_ready), '0);
        check("bp_main", out_data, 16'h0011);
        drive(1'b1, 16'h0033, 1'b0, 1'b0);
        tick();
        check("bp_hold_data", out_data, 16'h0011);
        check("bp_hold_occ", W'(occupancy), W'(2));
        drive(1'b1, 16'h0033, 1'b1, 1'b0);
        tick();
        check("drain_1", out_data, 16'h0022);
        tick();
        check("drain_2", out_data, 16'h0033);
        drive(1'b0, '0, 1'b1, 1'b0);
        tick();
        check("drain_empty", W'(out_valid), '0);

        // flush from TWO discards a concurrent input
        drive(1'b1, 16'h0044, 1'b0, 1'b0);
        tick();
        drive(1'b1, 16'h0055, 1'b0, 1'b0);
        tick();
        drive(1'b1, 16'h0066, 1'b0, 1'b1);
        tick();
        check("flush_occ", W'(occupancy), '0);
        check("flush_valid", W'(out_valid), '0);
        check("flush_data", out_data, RVAL);
        drive(1'b0, '0, 1'b1, 1'b0);
        repeat (2) tick();
        check("flush_no_66", W'(out_valid), '0);

        // asynchronous reset while holding one entry
        drive(1'b1, 16'h0077, 1'b0, 1'b0);
        tick();
        drive(1'b0, '0, 1'b0, 1'b0);
        check("pre_rst_valid", W'(out_valid), W'(1));
        #2 rst = 1'b0;
        #1;
        check("async_rst_valid", W'(out_valid), '0);
        check("async_rst_occ", W'(occupancy), '0);
        tick();
        rst = 1'b1;
        check("post_rst_ready", W'(in_ready), W'(1));

        // random traffic
        for (int i = 0; i < 400; i++) begin
            drive(1'($urandom_range(0, 1)), W'($urandom),
                  ($urandom_range(0, 3) != 0), ($urandom_range(0, 15) == 0));
            tick();
        end
        drive(1'b0, '0, 1'b1, 1'b0);
        repeat (3) tick();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
